// File: rtl/crc_pkg.sv
// Shared CRC definitions: mode codes, reset preset, FSM states,
// and width helpers used by the serial engine and frame sequencer.
package crc_pkg;

    localparam logic [1:0]  CRC_MODE_8  = 2'b00;
    localparam logic [1:0]  CRC_MODE_16 = 2'b01;
    localparam logic [1:0]  CRC_MODE_32 = 2'b10;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

    // Mode 2'b11 is treated as CRC32.
    function automatic logic [31:0] crc_mask(input logic [1:0] mode);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        unique case (1'b1)
            (mode == CRC_MODE_8):  m = 32'h0000_00FF;
            (mode == CRC_MODE_16): m = 32'h0000_FFFF;
            default:               m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic crc_msb(input logic [31:0] crc,
                                     input logic [1:0]  mode);
        logic b;
        b = crc[31];
        unique case (1'b1)
            (mode == CRC_MODE_8):  b = crc[7];
            (mode == CRC_MODE_16): b = crc[15];
            default:               b = crc[31];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/crc_serial_core.sv
// Serial CRC engine: one bit per clock, MSB-first, width set by mode.
// Ports: clk, rst_n, init (preset), data_valid/data_in (shift bit),
//   mode/poly (config), crc_out (engine register).
module crc_serial_core
    import crc_pkg::*;
#(
    parameter logic [31:0] INIT_VAL = CRC_INIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        data_valid,
    input  logic        data_in,
    input  logic [1:0]  mode,
    input  logic [31:0] poly,
    output logic [31:0] crc_out
);

    logic        rb;
    logic [31:0] nxt;

    assign rb  = crc_msb(crc_out, mode) ^ data_in;
    assign nxt = ((crc_out << 1) ^ (rb ? poly : 32'h0))
               & crc_mask(mode);

    // init wins over data_valid; the unmasked preset gets
    // trimmed to the mode width by the first shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_out <= INIT_VAL;
        end else if (init) begin
            crc_out <= INIT_VAL;
        end else if (data_valid) begin
            crc_out <= nxt;
        end
    end

endmodule

// File: rtl/crc_frame_seq.sv
// Framed byte front end for the serial CRC engine (8 clk per byte).
// Ports: clk, rst_n, cfg_mode/cfg_poly, s_valid/s_ready/s_data/s_last
//   (byte in), res_valid/res_ready/res_crc/res_len (result), busy.
module crc_frame_seq
    import crc_pkg::*;
#(
    parameter logic [31:0] INIT_VAL = CRC_INIT,
    parameter int          LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic [31:0]      cfg_poly,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_crc,
    output logic [LEN_W-1:0] res_len,
    output logic             busy
);

    seq_state_t  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_q;
    logic        last_q;
    logic [1:0]  mode_q;
    logic [31:0] poly_q;

    logic             bit0;
    logic             accept;
    logic             eng_init;
    logic             eng_valid;
    logic             eng_din;
    logic [LEN_W-1:0] len_inc;

    assign bit0 = (bit_cnt == 3'd0);

    // Gated by rst_n so the byte port is closed while reset is held.
    assign s_ready = rst_n
                   && ((state == ST_IDLE)
                    || (state == ST_WAIT)
                    || ((state == ST_SHIFT) && bit0 && !last_q));

    assign accept    = s_valid && s_ready;
    assign eng_init  = (state == ST_IDLE) && accept;
    assign eng_valid = (state == ST_SHIFT);
    assign eng_din   = byte_q[bit_cnt];

    assign len_inc = (&res_len) ? res_len
                                : res_len + LEN_W'(1);

    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    crc_serial_core #(
        .INIT_VAL   (INIT_VAL)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (eng_init),
        .data_valid (eng_valid),
        .data_in    (eng_din),
        .mode       (mode_q),
        .poly       (poly_q),
        .crc_out    (res_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            mode_q  <= CRC_MODE_32;
            poly_q  <= 32'h0;
            res_len <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        byte_q  <= s_data;
                        last_q  <= s_last;
                        mode_q  <= cfg_mode;
                        poly_q  <= cfg_poly;
                        res_len <= LEN_W'(1);
                        bit_cnt <= 3'd7;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt - 3'd1;
                    if (bit0) begin
                        if (last_q) begin
                            state <= ST_DONE;
                        end else if (accept) begin
                            // Next byte follows with no bubble.
                            byte_q  <= s_data;
                            last_q  <= s_last;
                            res_len <= len_inc;
                            bit_cnt <= 3'd7;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (accept) begin
                        byte_q  <= s_data;
                        last_q  <= s_last;
                        res_len <= len_inc;
                        bit_cnt <= 3'd7;
                        state   <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_seq.sv
// Scoreboard bench for crc_frame_seq: directed known answers
// plus random frames against a bit-serial reference model.
module tb_crc_frame_seq;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_poly;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_crc;
    logic [15:0] res_len;
    logic        busy;

    crc_frame_seq #(
        .INIT_VAL  (32'hFFFF_FFFF),
        .LEN_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_mode  (cfg_mode),
        .cfg_poly  (cfg_poly),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_crc   (res_crc),
        .res_len   (res_len),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] crc;
        int          len;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // CRC straight from the definition: W-bit register, preset
    // all ones, each message bit MSB first folds in the polynomial.
    function automatic logic [31:0] ref_crc(input logic [7:0] d[$],
                                            input logic [1:0] mode,
                                            input logic [31:0] poly);
        int w;
        longint unsigned m, c, p;
        bit top;
        w = (mode == 2'd0) ? 8 : (mode == 2'd1) ? 16 : 32;
        m = (64'd1 << w) - 64'd1;
        c = 64'hFFFF_FFFF & m;
        p = {32'h0, poly} & m;
        foreach (d[i]) begin
            for (int b = 7; b >= 0; b--) begin
                top = ((c >> (w - 1)) & 64'd1) != 0;
                top = top ^ d[i][b];
                c = ((c << 1) ^ (top ? p : 64'd0)) & m;
            end
        end
        return c[31:0];
    endfunction

    // ---------------- monitor ----------------
    bit          in_frame = 0;
    bit          rv_prev  = 0;
    int          first_cyc = 0;
    int          rise_cyc  = 0;
    logic [31:0] held_crc;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_frame = 0;
            rv_prev  = 0;
        end else begin
            if (s_valid && s_ready) begin
                if (!in_frame) begin
                    first_cyc = cyc;
                    in_frame  = 1;
                end
                if (s_last) in_frame = 0;
            end
            if (res_valid && !rv_prev) begin
                rise_cyc = cyc;
                held_crc = res_crc;
            end
            if (res_valid) begin
                chk("done_s_ready", 64'(s_ready), 64'd0);
                if (rv_prev && !res_ready)
                    chk("hold_crc", 64'(res_crc), 64'(held_crc));
                if (res_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result: got crc %0h expected none",
                                 res_crc);
                    end else begin
                        e = sb.pop_front();
                        chk("res_crc", 64'(res_crc), 64'(e.crc));
                        chk("res_len", 64'(res_len), 64'(e.len));
                        chk("latency", 64'(rise_cyc - first_cyc),
                            64'(e.lat));
                    end
                end
            end
            rv_prev = res_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        while (!s_ready && t < 400) begin
            step();
            t++;
        end
        if (t >= 400) chk("accept_timeout", 64'd1, 64'd0);
        step();
    endtask

    task automatic send_frame(input logic [7:0]  d[$],
                              input logic [1:0]  mode,
                              input logic [31:0] poly,
                              input int          idle,
                              input bit          scramble,
                              input bit          use_kat,
                              input logic [31:0] kat);
        exp_t e;
        int   n;
        n = d.size();
        e.crc = use_kat ? kat : ref_crc(d, mode, poly);
        e.len = n;
        e.lat = 9;
        for (int i = 1; i < n; i++)
            e.lat += (idle + 1 > 8) ? idle + 1 : 8;
        sb.push_back(e);
        cfg_mode = mode;
        cfg_poly = poly;
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], i == n - 1);
            if (i == 0 && scramble) begin
                cfg_mode = 2'($urandom);
                cfg_poly = $urandom;
            end
            s_valid = 1'b0;
            if (i < n - 1) repeat (idle) step();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"},   64'(s_ready),   64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_res_crc"},   64'(res_crc),   64'hFFFF_FFFF);
        chk({tag, "_res_len"},   64'(res_len),   64'd0);
    endtask

    logic [7:0] q123[$];
    logic [7:0] one[$];
    logic [7:0] rq[$];

    initial begin
        int t;
        rst_n     = 1'b0;
        cfg_mode  = 2'd0;
        cfg_poly  = 32'h07;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_last    = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 9; i++) q123.push_back(8'(8'h31 + i));

        #23;
        check_reset_vals("reset");
        step();
        rst_n = 1'b1;
        step();
        chk("idle_s_ready", 64'(s_ready), 64'd1);

        // 1: CRC8 single zero byte
        one = '{8'h00};
        send_frame(one, 2'd0, 32'h07, 0, 0, 1, 32'h0000_00F3);
        repeat (12) step();

        // 2: CRC16 back to back
        send_frame(q123, 2'd1, 32'h1021, 0, 0, 1, 32'h0000_29B1);
        repeat (12) step();

        // 3: CRC32 with idle gaps long enough to park in WAIT
        send_frame(q123, 2'd2, 32'h04C1_1DB7, 10, 0, 1, 32'h0376_E6E7);
        repeat (12) step();

        // 4: result back-pressure while the next frame waits
        res_ready = 1'b0;
        one = '{8'h00};
        send_frame(one, 2'd0, 32'h07, 0, 0, 1, 32'h0000_00F3);
        fork
            begin
                rq = '{8'h31, 8'h32};
                send_frame(rq, 2'd1, 32'h1021, 0, 0, 0, 32'h0);
            end
            begin
                t = 0;
                while (!res_valid && t < 50) begin
                    step();
                    t++;
                end
                if (t >= 50) chk("done_timeout", 64'd1, 64'd0);
                repeat (20) step();
                chk("held_res_valid", 64'(res_valid), 64'd1);
                res_ready = 1'b1;
            end
        join
        repeat (30) step();

        // 5: config churn after the first byte is ignored
        send_frame(q123, 2'd1, 32'h1021, 0, 1, 1, 32'h0000_29B1);
        repeat (12) step();

        // 6: reset at bit 3 of byte 4, then rerun
        cfg_mode = 2'd1;
        cfg_poly = 32'h1021;
        for (int i = 0; i < 4; i++) begin
            send_byte(q123[i], 1'b0);
        end
        s_valid = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        step();
        step();
        rst_n = 1'b1;
        step();
        send_frame(q123, 2'd1, 32'h1021, 0, 0, 1, 32'h0000_29B1);
        repeat (12) step();

        // random frames against the reference model
        for (int f = 0; f < 14; f++) begin
            int n;
            logic [31:0] p;
            rq = {};
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) rq.push_back(8'($urandom));
            p = $urandom | 32'h1;
            send_frame(rq, 2'($urandom), p,
                       $urandom_range(0, 11), 1'($urandom), 0, 32'h0);
        end

        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            step();
            t++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
